gctr_block: RTL and testbench
=============================

// Module: gctr_block
// PURPOSE
//  AES-GCM GCTR engine with one shared AES-128/256 encrypt core.
//  Each command produces one of three results:
//   - hash key H = E(K,0^128)
//   - tag mask E(K,Y0)
//   - one CTR block C = P xor E(K,Y_i), which also serves as decrypt.
//  Sits between the GCM top-level sequencer and the GHASH unit.
// PARAMETERS
//  none (AES variant chosen at run time by iKeylen)
// PORTS
//  iClk          in   1    clock; single clock domain
//  iRstn         in   1    asynchronous active-low reset
//  iInit         in   1    one-cycle command strobe; samples all inputs below
//  iIV           in   96   IV [0:95]; bit 0 is MSB
//  iIV_valid     in   1    IV qualifier
//  iKey          in   256  key [0:255]; AES-128 uses iKey[0:127]
//  iKey_valid    in   1    key qualifier
//  iKeylen       in   1    0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14)
//  iY0           in   1    command: compute E(K, IV||32'h1)
//  iHashKey      in   1    command: compute E(K, 0^128)
//  iBlock        in   128  plaintext or ciphertext block [0:127]
//  iBlock_valid  in   1    command: CTR-process iBlock
//  oResult       out  128  result [0:127]
//  oResult_valid out  1    result valid; level signal held until next accepted command
// BEHAVIOUR
//  Reset (async, iRstn=0):
//   - oResult = 0, oResult_valid = 0, counter ctr = 32'h1, FSM = IDLE.
//  Accept:
//   - A command is accepted on a rising iClk with iInit=1 and iKey_valid=1, in IDLE or DONE.
//   - Priority: iHashKey > iY0 > iBlock_valid.
//   - iY0 and iBlock_valid commands also require iIV_valid=1.
//   - Otherwise iInit is ignored and state and outputs are unchanged.
//   - iInit while BUSY is ignored.
//  On accept:
//   - Inputs are latched internally, so the caller need not hold them.
//   - oResult_valid drops to 0 on the next edge.
//  AES input per command:
//   - HashKey: 128'h0.
//   - Y0: {IV, 32'h00000001}; ctr is unchanged.
//   - Block: ctr <= ctr+1 (mod 2^32), then AES input = {IV, new ctr}.
//     The first block after reset therefore uses 32'h2.
//  Output per command:
//   - HashKey and Y0: oResult = E(K,Y).
//   - Block: oResult = iBlock xor E(K,Y).
//   - Decryption is the identical operation on a ciphertext input.
//  FSM: IDLE -> BUSY on accept; BUSY -> DONE when the core finishes; DONE -> BUSY on accept.
//  Core timing: iterative AES, one round per cycle, round keys expanded on the fly.
//  Latency: oResult_valid rises exactly Nr+2 cycles after the accepting edge:
//   - 12 cycles for AES-128, 16 cycles for AES-256.
//  Hold: oResult and oResult_valid stay stable indefinitely in DONE.
//  ctr is cleared only by reset:
//   - It persists across HashKey and Y0 commands.
//   - It wraps from 2^32-1 to 0.
//  Reset asserted mid-operation aborts immediately to reset values.
//  iKeylen is latched per command; a key-length change between commands is legal.
// STRUCTURE
//  Shared package gcm_pkg:
//   - AES S-box function, Rcon table, Nr constants (10/14), block/key width constants.
//  One sub-module aes_core_iter:
//   - iterative encrypt-only AES-128/256 with start/key/keylen/block inputs and done/result outputs.
//  gctr_block holds the FSM, counter, input latches, the output XOR and the output register.
// TESTING
//  AES-256, K=E3C08A8F06C6E3AD95A70557B23F75483CE33021A9C72B7025666204C69C0B72, IV=12153524C0895E81B2C28465:
//  1. HashKey after reset -> oResult=286D73994EA0BA3CFD1F52BF06A8ACF2, valid after 16 cycles.
//  2. Blocks in sequence -> ciphertext; ctr 2,3,4 used:
//     08000F101112131415161718191A1B1C -> E2006EB42F5277022D9B19925BC419D7
//     1D1E1F202122232425262728292A2B2C -> A592666C925FE2EF718EB4E308EFEAA7
//     2D2E2F303132333435363738393A0002 -> C5273B394118860A5BE2A97F56AB7836
//  3. Y0 command -> 714D54FDCFCEE37D5729CDDAB383A016; a following block still uses ctr=5.
//  4. Reset, HashKey, then feed the three ciphertexts -> the three plaintexts above.
//  5. Idle 100 cycles after a result -> oResult and oResult_valid unchanged.
//     iInit with iKey_valid=0 -> no change.
//  6. Reset, then AES-128 with K=AD7A2BD03EAC835A6F620FDCB506B345:
//     HashKey, blocks and Y0 match a software AES-GCM model; valid after 12 cycles.
//     Reset mid-BUSY -> outputs 0; next block uses ctr=2.

Source files
------------

// File: rtl/gcm_pkg.sv
// Shared AES/GCM definitions: widths, round counts, FSM/command enums, GF(2^8) helpers.
// Latency: n/a (pure functions, combinational when used).
// Backpressure: n/a.
package gcm_pkg;

  localparam int BLK_W = 128;
  localparam int KEY_W = 256;
  localparam int IV_W  = 96;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} gctr_state_e;
  typedef enum logic [1:0] {CMD_HASH = 2'd0, CMD_Y0 = 2'd1, CMD_BLOCK = 2'd2} gctr_cmd_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box built from its definition: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One 4-word key-schedule step: base supplies the words being xored, last_w the word fed
  // through SubWord (with RotWord/Rcon when rot is set).
  function automatic logic [127:0] key_step(input logic [127:0] base, input logic [31:0] last_w,
                                            input logic rot, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = rot ? (sub_word({last_w[23:0], last_w[31:24]}) ^ {rc, 24'h0}) : sub_word(last_w);
    w0 = base[127:96] ^ t;
    w1 = base[95:64]  ^ w0;
    w2 = base[63:32]  ^ w1;
    w3 = base[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_core_iter.sv
// Iterative encrypt-only AES-128/256, one round per cycle, round keys expanded on the fly.
// Latency: start edge + Nr+1 edges to the one-cycle done pulse; result holds until next start.
// Backpressure: none; start is only legal while idle, start wins if raised early.
module aes_core_iter
  import gcm_pkg::*;
(
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic             keylen,
  input  logic [BLK_W-1:0] block,
  output logic             done,
  output logic [BLK_W-1:0] result
);

  logic [127:0] state_q;
  logic [127:0] k_prev_q;
  logic [127:0] k_cur_q;
  logic [3:0]   round_q;
  logic         busy_q;
  logic         len256_q;
  logic         done_q;

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [127:0] mixed;
  logic [127:0] round_out;
  logic [127:0] next_key;
  logic [3:0]   round_nx;
  logic         last_round;

  // One AES round on the current state; MixColumns is skipped in the final round.
  always_comb begin
    last_round = (round_q == (len256_q ? NR_256 : NR_128));
    for (int i = 0; i < 16; i++) sb[i] = sbox(state_q[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = last_round ? {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]}
                                         : mix_col({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
    end
    round_out = mixed ^ k_cur_q;
  end

  // Round key for the following round; AES-256 alternates RotWord+Rcon and plain SubWord steps.
  always_comb begin
    round_nx = round_q + 4'd1;
    next_key = len256_q ? key_step(k_prev_q, k_cur_q[31:0], ~round_nx[0], rcon(round_nx >> 1))
                        : key_step(k_cur_q, k_cur_q[31:0], 1'b1, rcon(round_nx));
  end

  // Initial AddRoundKey on start, then one round per cycle until the last round.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q  <= '0;
      k_prev_q <= '0;
      k_cur_q  <= '0;
      round_q  <= '0;
      busy_q   <= 1'b0;
      len256_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q  <= block ^ key[255:128];
        k_prev_q <= key[255:128];
        k_cur_q  <= keylen ? key[127:0] : key_step(key[255:128], key[159:128], 1'b1, 8'h01);
        round_q  <= 4'd1;
        busy_q   <= 1'b1;
        len256_q <= keylen;
      end else if (busy_q) begin
        state_q <= round_out;
        if (last_round) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          k_prev_q <= k_cur_q;
          k_cur_q  <= next_key;
          round_q  <= round_nx;
        end
      end
    end
  end

  assign done   = done_q;
  assign result = state_q;

endmodule

// File: rtl/gctr_block.sv
// GCTR engine: hash key, tag mask or one CTR block per command through a shared AES core.
// Latency: oResult_valid rises Nr+2 cycles after the accepting edge (12 / 16).
// Backpressure: commands arriving while BUSY are dropped; result is held until next accept.
module gctr_block
  import gcm_pkg::*;
(
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             iInit,
  input  logic [IV_W-1:0]  iIV,
  input  logic             iIV_valid,
  input  logic [KEY_W-1:0] iKey,
  input  logic             iKey_valid,
  input  logic             iKeylen,
  input  logic             iY0,
  input  logic             iHashKey,
  input  logic [BLK_W-1:0] iBlock,
  input  logic             iBlock_valid,
  output logic [BLK_W-1:0] oResult,
  output logic             oResult_valid
);

  gctr_state_e      state_q, state_nx;
  gctr_cmd_e        cmd_q, cmd_in;
  logic [IV_W-1:0]  iv_q;
  logic [KEY_W-1:0] key_q;
  logic             keylen_q;
  logic [BLK_W-1:0] blk_q;
  logic [31:0]      ctr_q;
  logic             start_q;
  logic             accept;
  logic             core_done;
  logic [BLK_W-1:0] core_result;
  logic [BLK_W-1:0] aes_in;

  // Command decode with HashKey > Y0 > Block priority; IV is only needed for counter blocks.
  always_comb begin
    cmd_in = CMD_BLOCK;
    if (iHashKey)  cmd_in = CMD_HASH;
    else if (iY0)  cmd_in = CMD_Y0;
    accept = iInit && iKey_valid && (state_q != ST_BUSY) &&
             (iHashKey || (iIV_valid && (iY0 || iBlock_valid)));
  end

  // FSM state register.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // FSM next state: accept from IDLE/DONE, finish when the core reports done.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (accept)    state_nx = ST_BUSY;
      ST_BUSY:          if (core_done) state_nx = ST_DONE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  // Latch the command and its operands; the counter advances only for block commands.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      cmd_q    <= CMD_HASH;
      iv_q     <= '0;
      key_q    <= '0;
      keylen_q <= 1'b0;
      blk_q    <= '0;
      ctr_q    <= 32'h1;
      start_q  <= 1'b0;
    end else begin
      start_q <= accept;
      if (accept) begin
        cmd_q    <= cmd_in;
        iv_q     <= iIV;
        key_q    <= iKey;
        keylen_q <= iKeylen;
        blk_q    <= iBlock;
        if (cmd_in == CMD_BLOCK) ctr_q <= ctr_q + 32'd1;
      end
    end
  end

  // Counter block fed to AES: zero for H, IV||1 for the tag mask, IV||ctr for data.
  always_comb begin
    aes_in = '0;
    if (cmd_q != CMD_HASH) aes_in = {iv_q, (cmd_q == CMD_Y0) ? 32'h1 : ctr_q};
  end

  aes_core_iter u_aes (
    .iClk   (iClk),
    .iRstn  (iRstn),
    .start  (start_q),
    .key    (key_q),
    .keylen (keylen_q),
    .block  (aes_in),
    .done   (core_done),
    .result (core_result)
  );

  // Output register: cleared valid on accept, loaded (with data XOR for blocks) on core done.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      oResult       <= '0;
      oResult_valid <= 1'b0;
    end else if (accept) begin
      oResult_valid <= 1'b0;
    end else if (state_q == ST_BUSY && core_done) begin
      oResult       <= core_result ^ ((cmd_q == CMD_BLOCK) ? blk_q : '0);
      oResult_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gctr_block.sv
`timescale 1ns/1ps
module tb_gctr_block;

  logic         iClk = 1'b0;
  logic         iRstn = 1'b0;
  logic         iInit = 1'b0;
  logic [95:0]  iIV = '0;
  logic         iIV_valid = 1'b0;
  logic [255:0] iKey = '0;
  logic         iKey_valid = 1'b0;
  logic         iKeylen = 1'b0;
  logic         iY0 = 1'b0;
  logic         iHashKey = 1'b0;
  logic [127:0] iBlock = '0;
  logic         iBlock_valid = 1'b0;
  logic [127:0] oResult;
  logic         oResult_valid;

  gctr_block dut (
    .iClk          (iClk),
    .iRstn         (iRstn),
    .iInit         (iInit),
    .iIV           (iIV),
    .iIV_valid     (iIV_valid),
    .iKey          (iKey),
    .iKey_valid    (iKey_valid),
    .iKeylen       (iKeylen),
    .iY0           (iY0),
    .iHashKey      (iHashKey),
    .iBlock        (iBlock),
    .iBlock_valid  (iBlock_valid),
    .oResult       (oResult),
    .oResult_valid (oResult_valid)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  // Known-answer vectors (MACsec GCM-AES-256/128 and GCM zero-key cases).
  localparam logic [255:0] K256  = 256'hE3C08A8F06C6E3AD95A70557B23F75483CE33021A9C72B7025666204C69C0B72;
  localparam logic [255:0] K128  = {128'hAD7A2BD03EAC835A6F620FDCB506B345, 128'h0};
  localparam logic [95:0]  IVA   = 96'h12153524C0895E81B2C28465;
  localparam logic [127:0] P1    = 128'h08000F101112131415161718191A1B1C;
  localparam logic [127:0] P2    = 128'h1D1E1F202122232425262728292A2B2C;
  localparam logic [127:0] P3    = 128'h2D2E2F303132333435363738393A0002;
  localparam logic [127:0] C1    = 128'hE2006EB42F5277022D9B19925BC419D7;
  localparam logic [127:0] C2    = 128'hA592666C925FE2EF718EB4E308EFEAA7;
  localparam logic [127:0] C3    = 128'hC5273B394118860A5BE2A97F56AB7836;
  localparam logic [127:0] H256  = 128'h286D73994EA0BA3CFD1F52BF06A8ACF2;
  localparam logic [127:0] Y0256 = 128'h714D54FDCFCEE37D5729CDDAB383A016;
  localparam logic [127:0] H128  = 128'h73A23D80121DE2D5A850253FCF43120E;
  localparam logic [127:0] Y0128 = 128'hEB4E051CB548A6B5490F6F11A27CB7D0;
  localparam logic [127:0] C1_128 = 128'h701AFA1CC039C0D765128A665DAB6924;
  localparam logic [127:0] HZ128 = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
  localparam logic [127:0] YZ128 = 128'h58E2FCCEFA7E3061367F1D57A4E7455A;
  localparam logic [127:0] HZ256 = 128'hDC95C078A2408989AD48A21492842087;
  localparam logic [127:0] YZ256 = 128'h530F8AFBC74536B9A963B4F1C4CB738B;
  localparam logic [127:0] CZ256 = 128'hCEA7403D4D606B6E074EC5D3BAF39D18;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] res;
    int           acc;
    int           lat;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic prev_vld = 1'b0;

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %032h expected %032h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: on every rising edge of oResult_valid pop the oldest expectation and compare.
  always @(negedge iClk) begin
    if (!iRstn) begin
      prev_vld = 1'b0;
    end else begin
      if (oResult_valid && !prev_vld) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %032h with nothing expected", oResult);
        end else begin
          mon_e = sb_q.pop_front();
          check128(mon_e.name, oResult, mon_e.res);
          check_int({mon_e.name, "_latency"}, cyc - mon_e.acc, mon_e.lat);
        end
      end
      prev_vld = oResult_valid;
    end
  end

  // Drive one command for one cycle; operands are scrambled afterwards to prove they were latched.
  task automatic issue(input string name, input logic hk, input logic y0, input logic bv,
                       input logic [255:0] k, input logic kl, input logic [95:0] iv,
                       input logic [127:0] blk, input logic [127:0] exp, input logic expect_res);
    exp_t e;
    @(negedge iClk);
    iInit = 1'b1; iHashKey = hk; iY0 = y0; iBlock_valid = bv;
    iKey = k; iKey_valid = 1'b1; iKeylen = kl; iIV = iv; iIV_valid = 1'b1; iBlock = blk;
    if (expect_res) begin
      e.res = exp; e.acc = cyc + 1; e.lat = kl ? 16 : 12; e.name = name;
      sb_q.push_back(e);
    end
    @(posedge iClk); #1;
    iInit = 1'b0; iHashKey = 1'b0; iY0 = 1'b0; iBlock_valid = 1'b0;
    iKey = ~k; iKeylen = ~kl; iIV = ~iv; iBlock = ~blk;
    @(negedge iClk);
    check_int({name, "_vld_drop"}, int'(oResult_valid), 0);
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    while (!oResult_valid && n < 40) begin
      @(negedge iClk);
      n++;
    end
    if (!oResult_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: valid 0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic run(input string name, input logic hk, input logic y0, input logic bv,
                     input logic [255:0] k, input logic kl, input logic [95:0] iv,
                     input logic [127:0] blk, input logic [127:0] exp);
    issue(name, hk, y0, bv, k, kl, iv, blk, exp, 1'b1);
    wait_result(name);
  endtask

  // A command strobe that must be ignored (missing qualifier or engine busy).
  task automatic pulse(input logic hk, input logic y0, input logic bv, input logic kv,
                       input logic ivv, input logic [255:0] k, input logic [127:0] blk);
    @(negedge iClk);
    iInit = 1'b1; iHashKey = hk; iY0 = y0; iBlock_valid = bv; iKey_valid = kv;
    iIV_valid = ivv; iKey = k; iKeylen = 1'b1; iIV = IVA; iBlock = blk;
    @(posedge iClk); #1;
    iInit = 1'b0; iHashKey = 1'b0; iY0 = 1'b0; iBlock_valid = 1'b0;
    iKey_valid = 1'b1; iIV_valid = 1'b1;
  endtask

  task automatic check_hold(input string name, input int n, input logic [127:0] exp);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge iClk);
      if (oResult !== exp || oResult_valid !== 1'b1) bad++;
    end
    check_int(name, bad, 0);
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iRstn = 1'b0;
    repeat (2) @(negedge iClk);
    iRstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge iClk);
    check128("reset_result", oResult, 128'h0);
    check_int("reset_valid", int'(oResult_valid), 0);
    iRstn = 1'b1;

    // AES-256: counter progression with Y0/HashKey interleaved and a busy-time strobe.
    run("h256", 1, 0, 0, K256, 1, IVA, '0, H256);
    run("enc1_ctr2", 0, 0, 1, K256, 1, IVA, P1, C1);
    run("y0_256", 0, 1, 0, K256, 1, IVA, '0, Y0256);
    issue("enc2_ctr3", 0, 0, 1, K256, 1, IVA, P2, C2, 1'b1);
    repeat (3) @(negedge iClk);
    pulse(0, 0, 1, 1, 1, K256, P3);
    wait_result("enc2_ctr3");
    run("h256_again", 1, 0, 0, K256, 1, IVA, '0, H256);
    run("enc3_ctr4", 0, 0, 1, K256, 1, IVA, P3, C3);

    // Decrypt after reset recovers the plaintext.
    do_reset();
    run("h256_rst", 1, 0, 0, K256, 1, IVA, '0, H256);
    run("dec1", 0, 0, 1, K256, 1, IVA, C1, P1);
    run("dec2", 0, 0, 1, K256, 1, IVA, C2, P2);
    run("dec3", 0, 0, 1, K256, 1, IVA, C3, P3);

    // Hold in DONE and ignore unqualified strobes.
    check_hold("hold_idle", 100, P3);
    pulse(1, 0, 0, 0, 1, K256, P1);
    check_hold("ignore_no_key", 20, P3);
    pulse(0, 1, 0, 1, 0, K256, P1);
    check_hold("ignore_y0_no_iv", 20, P3);
    pulse(0, 0, 1, 1, 0, K256, P1);
    check_hold("ignore_blk_no_iv", 20, P3);

    // AES-128 with reset mid-operation.
    do_reset();
    run("h128", 1, 0, 0, K128, 0, IVA, '0, H128);
    run("y0_128", 0, 1, 0, K128, 0, IVA, '0, Y0128);
    run("enc128_ctr2", 0, 0, 1, K128, 0, IVA, P1, C1_128);
    issue("abort", 0, 0, 1, K128, 0, IVA, P2, '0, 1'b0);
    repeat (4) @(negedge iClk);
    iRstn = 1'b0;
    #1;
    check128("abort_result", oResult, 128'h0);
    check_int("abort_valid", int'(oResult_valid), 0);
    @(negedge iClk);
    iRstn = 1'b1;
    run("enc128_after_abort", 0, 0, 1, K128, 0, IVA, P1, C1_128);

    // Zero-key vectors, switching key length between commands.
    do_reset();
    run("hz128", 1, 0, 0, '0, 0, '0, '0, HZ128);
    run("yz128", 0, 1, 0, '0, 0, '0, '0, YZ128);
    run("hz256", 1, 0, 0, '0, 1, '0, '0, HZ256);
    run("yz256", 0, 1, 0, '0, 1, '0, '0, YZ256);
    run("cz256", 0, 0, 1, '0, 1, '0, '0, CZ256);

    repeat (5) @(negedge iClk);
    check_int("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
